// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences a UART receiver and buffers its bytes in a FIFO for CPU reads.
// Optional UART_RX_CTRL_OVF_FLAG_EN mirrors the overflow flag into out[14].
module uart_rx_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   rx_out,
    output logic          rx_clear,
    input  logic          load,
    output logic [15:0]   out,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr
);
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_WAIT} state_t;
    state_t        r_state, w_next;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_count;
    logic          r_ovf, r_rx_clear;
    logic          w_cap, w_full, w_pop, w_push, w_drop, w_flag;
    logic          w_unused;
    assign w_unused = ^rx_out[14:8];
    always_comb begin
        w_next = r_state;
        w_cap  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cap  = !rx_out[15];
                w_next = rx_out[15] ? S_IDLE : S_CLEAR;
            end
            S_CLEAR: w_next = S_WAIT;
            S_WAIT:  w_next = rx_out[15] ? S_IDLE : S_WAIT;
            default: w_next = S_CLEAR;
        endcase
    end
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the byte.
    assign w_full = r_count == (AW+1)'(DEPTH);
    assign w_pop  = load && (r_count != '0);
    assign w_push = w_cap && (!w_full || w_pop);
    assign w_drop = w_cap && w_full && !w_pop;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_CLEAR;
            r_rx_clear <= 1'b1;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rx_clear <= w_next == S_CLEAR;
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop) r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            if (w_drop) r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= rx_out[7:0];
    end
`ifdef UART_RX_CTRL_OVF_FLAG_EN
    assign w_flag = r_ovf;
`else
    assign w_flag = 1'b0;
`endif
    assign out      = (r_count == '0) ? {1'b1, w_flag, 14'h0} : {1'b0, w_flag, 6'h0, r_mem[r_rd]};
    assign rx_clear = r_rx_clear;
    assign count    = r_count;
    assign overflow = r_ovf;
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sequences the UART receiver and buffers its bytes for the CPU memory map. It watches the receiver's 16-bit output word, where bit15=1 means no data. Each received byte is pushed into an internal FIFO, and the controller then pulses the receiver's synchronous clear to re-arm it. The CPU side sees the same word format as the bare receiver (16'h8000 = empty) and pops with a one-cycle load strobe.

Parameters:
DEPTH, 16, FIFO entries; power of 2, range 2..256
AW, 4, pointer width; must equal log2(DEPTH)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
rx_out  in  16  receiver output word; bit15=1 means empty, else {8'h00, byte}
rx_clear  out  1  synchronous clear to the receiver; registered
load  in  1  CPU pop strobe; one pop per cycle asserted
out  out  16  CPU read word: 16'h8000 if FIFO empty, else {8'h00, head byte}
count  out  AW+1  FIFO occupancy, 0..DEPTH
overflow  out  1  sticky: a byte arrived while the FIFO was full and was dropped
ovf_clr  in  1  clears overflow

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted:
  - state=CLEAR, rx_clear=1, FIFO empty (pointers 0, count=0), overflow=0, out=16'h8000.
  - Effect: any stale byte held in the receiver is discarded after reset.
- FSM, all states registered:
  - IDLE: rx_clear=0. If rx_out[15]==0, capture rx_out[7:0] this cycle (push, or drop if full) and go to CLEAR.
  - CLEAR: rx_clear=1 for exactly one cycle, then go to WAIT.
  - WAIT: rx_clear=0. Stay until rx_out[15]==1, then go to IDLE. This prevents re-capturing the same byte.
- Capture-to-rx_clear latency is 1 cycle. A byte first visible in IDLE at edge n is pushed at edge n+1, and rx_clear is high during cycle n+1..n+2.
- Each byte is pushed exactly once, regardless of how long rx_out is held.
- FIFO:
  - Circular buffer. Write and read pointers are AW bits and wrap DEPTH-1 -> 0.
  - count is a separate AW+1-bit register.
  - out is combinational from the head entry and count (no read latency).
  - load with count>0: read pointer advances and count decrements on that edge. The next head is presented the following cycle.
  - load with count==0: ignored, with no pointer or count change.
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - count==DEPTH with a same-cycle pop: the push is accepted (the slot is freed that cycle).
  - count==0 with a same-cycle push: the load is ignored, and the byte becomes visible next cycle.
- Full FIFO (count==DEPTH) with a push and no pop:
  - Byte dropped, overflow set to 1.
  - The FSM still proceeds through CLEAR so the receiver re-arms.
- overflow clearing:
  - Cleared by ovf_clr on the next edge.
  - If ovf_clr coincides with a new overflow event, overflow ends at 1 (set wins).
- Reset mid-operation (any state, any FIFO fill) returns to the reset values immediately.
- The bytes in out and rx_out are treated as unsigned 8-bit. Bits 14:8 of out are 0 unless the optional feature is enabled.

Optional Feature:
- Macro: UART_RX_CTRL_OVF_FLAG_EN.
- Defined: out[14] mirrors overflow in both word forms. Empty reads 16'hC000 when overflow=1; data reads {1'b0, 1'b1, 6'b0, byte}.
- Undefined: out[14] is always 0. overflow remains available only on its own port.

Test Plan:
- Reset held 3 cycles, then released with rx_out=16'h0041 (stale) -> rx_clear=1 during reset; stub receiver drops to 16'h8000; out=16'h8000, count=0.
- Stub receiver presents 16'h0055, returning to 16'h8000 one cycle after rx_clear -> exactly one rx_clear pulse; count=1; out=16'h0055; load -> out=16'h8000, count=0.
- Hold rx_out=16'h0033 for 5 cycles before the receiver clears -> only one push; count=1.
- Push 0x01..0x10 with DEPTH=16, then 0x11 -> count=16, 0x11 dropped, overflow=1, rx_clear still pulsed. Pop all: values 0x01..0x10 in order.
- count=16 with load and a new byte 0x22 in the same cycle -> count stays 16; 0x22 is the tail, read out last.
- Push 2 bytes, assert reset mid-WAIT -> count=0, out=16'h8000, overflow=0, rx_clear=1. With UART_RX_CTRL_OVF_FLAG_EN and overflow=1, an empty read gives 16'hC000.
